// File: rtl/stopwatch_100hz_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_100hz_pkg
//  Brief    : Shared types and helpers for the 100 Hz stopwatch and its
//             7-segment scan driver (FSM state encoding, BCD->segment table).
//  Revision : 1.0  initial release
// ============================================================================
package stopwatch_100hz_pkg;

  // Stopwatch control states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

  // All cathodes off (active-low)
  localparam logic [6:0] C_SEG_BLANK = 7'h7F;

  // Active-low BCD -> {g,f,e,d,c,b,a}; non-decimal codes show blank
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = C_SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_100hz_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan
//  Brief    : Time-multiplexed driver for a 4-digit common-anode 7-segment
//             display. Free-running scan counter, digit mux, decoder and
//             registered an/seg/dp so digit changes are glitch-free.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan
  import stopwatch_100hz_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [SCAN_BITS-1:0] scan_cnt_q;
  logic [1:0]           w_sel;
  logic [3:0]           an_d;
  logic [3:0]           digit_d;
  logic                 dp_d;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;
  logic                 dp_q;

  assign w_sel = scan_cnt_q[SCAN_BITS-1 -: 2];

  // Free-running scan counter; top two bits pick the active digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Select anode, digit nibble and decimal point for the current slot
  always_comb begin
    an_d    = 4'b1111;
    digit_d = 4'd0;
    dp_d    = 1'b1;
    case (w_sel)
      2'd0: begin an_d = 4'b1110; digit_d = digits[3:0];                end
      2'd1: begin an_d = 4'b1101; digit_d = digits[7:4];                end
      2'd2: begin an_d = 4'b1011; digit_d = digits[11:8]; dp_d = 1'b0;  end
      2'd3: begin an_d = 4'b0111; digit_d = digits[15:12];              end
      default: begin an_d = 4'b1111; digit_d = 4'd0; dp_d = 1'b1;       end
    endcase
  end

  // Register display outputs together so anode and cathodes switch in step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1111;
      seg_q <= C_SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= bcd_to_seg(digit_d);
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_100hz.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_100hz
//  Brief    : 4-digit BCD stopwatch (SS.cc) advanced by rising edges of a
//             100 Hz data signal. Start/stop and lap/clear buttons drive a
//             4-state FSM; a lap latch freezes the display while counting
//             continues. Display driven through seg_scan.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_100hz
  import stopwatch_100hz_pkg::*;
#(
  parameter int         SCAN_BITS  = 18,
  parameter logic [3:0] MAX_TENS_S = 4'd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk100,
  input  logic        btn_start,
  input  logic        btn_lap,
  output logic [15:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        running,
  output logic        wrap
);

  // Edge detection / synchronisation
  logic       slow_q;
  logic       slow_dly_q;
  logic [2:0] start_sync_q;
  logic [2:0] lap_sync_q;
  logic       w_tick;
  logic       w_start_p;
  logic       w_lap_p;

  // Control and datapath state
  sw_state_e   state_q;
  logic        running_q;
  logic [15:0] count_q;
  logic [15:0] lap_q;
  logic        wrap_q;

  // Datapath next-state helpers
  logic [15:0] count_inc_d;
  logic        wrap_inc_d;
  logic        w_inc_en;
  logic        w_clear;
  logic        w_capture;
  logic [15:0] w_disp;

  assign w_tick    = slow_q & ~slow_dly_q;
  assign w_start_p = start_sync_q[1] & ~start_sync_q[2];
  assign w_lap_p   = lap_sync_q[1]   & ~lap_sync_q[2];

  // Sample the 100 Hz wave and the two buttons; older stage feeds the edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_q       <= 1'b0;
      slow_dly_q   <= 1'b0;
      start_sync_q <= 3'b000;
      lap_sync_q   <= 3'b000;
    end else begin
      slow_q       <= slow_clk100;
      slow_dly_q   <= slow_q;
      start_sync_q <= {start_sync_q[1:0], btn_start};
      lap_sync_q   <= {lap_sync_q[1:0], btn_lap};
    end
  end

  // Control FSM: start has priority over lap when both pulse together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_start_p) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_start_p) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (w_lap_p) begin
            state_q   <= ST_LAP;
            running_q <= 1'b1;
          end
        end
        ST_LAP: begin
          if (w_start_p) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (w_lap_p) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (w_start_p) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end else if (w_lap_p) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Ripple BCD increment; ">=" keeps a corrupted digit from ever exceeding 9
  always_comb begin
    count_inc_d = count_q;
    wrap_inc_d  = 1'b0;
    if (count_q[3:0] < 4'd9) begin
      count_inc_d[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc_d[3:0] = 4'd0;
      if (count_q[7:4] < 4'd9) begin
        count_inc_d[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc_d[7:4] = 4'd0;
        if (count_q[11:8] < 4'd9) begin
          count_inc_d[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc_d[11:8] = 4'd0;
          if (count_q[15:12] < MAX_TENS_S) begin
            count_inc_d[15:12] = count_q[15:12] + 4'd1;
          end else begin
            count_inc_d[15:12] = 4'd0;
            wrap_inc_d         = 1'b1;
          end
        end
      end
    end
  end

  // Datapath controls decode from the current (pre-transition) state
  assign w_inc_en  = w_tick & ((state_q == ST_RUN) | (state_q == ST_LAP));
  assign w_clear   = (state_q == ST_PAUSE) & w_lap_p & ~w_start_p;
  assign w_capture = (state_q == ST_RUN)   & w_lap_p & ~w_start_p;

  // Live count, lap latch and wrap pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
      lap_q   <= 16'h0000;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (w_clear) begin
        count_q <= 16'h0000;
        lap_q   <= 16'h0000;
      end else begin
        if (w_inc_en) begin
          count_q <= count_inc_d;
          wrap_q  <= wrap_inc_d;
        end
        if (w_capture) begin
          lap_q <= count_q;
        end
      end
    end
  end

  assign w_disp = (state_q == ST_LAP) ? lap_q : count_q;

  seg_scan #(
    .SCAN_BITS (SCAN_BITS)
  ) u_seg_scan (
    .clk    (clk),
    .reset  (reset),
    .digits (w_disp),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  assign bcd     = count_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_100hz.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_100hz
//  Brief    : Directed, self-checking bench for stopwatch_100hz (SCAN_BITS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_100hz;

  logic        clk = 1'b0;
  logic        reset;
  logic        slow;
  logic        bs;
  logic        bl;
  logic [15:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        running;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  localparam int OP_TICK  = 0;
  localparam int OP_START = 1;
  localparam int OP_LAP   = 2;
  localparam int OP_BOTH  = 3;

  typedef struct {
    int          op;
    int          n;
    logic [15:0] exp_bcd;
    logic        exp_run;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stopwatch_100hz #(
    .SCAN_BITS  (4),
    .MAX_TENS_S (4'd9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slow_clk100 (slow),
    .btn_start   (bs),
    .btn_lap     (bl),
    .bcd         (bcd),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .running     (running),
    .wrap        (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic l);
    bs = s;
    bl = l;
    step(6);
    bs = 1'b0;
    bl = 1'b0;
    step(6);
  endtask

  task automatic ticks(input int n, input int half);
    repeat (n) begin
      slow = 1'b1;
      step(half);
      slow = 1'b0;
      step(half);
    end
    step(4);
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'h40: return 4'd0;
      7'h79: return 4'd1;
      7'h24: return 4'd2;
      7'h30: return 4'd3;
      7'h19: return 4'd4;
      7'h12: return 4'd5;
      7'h02: return 4'd6;
      7'h78: return 4'd7;
      7'h00: return 4'd8;
      7'h10: return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  // Watch the scan for more than one full period and rebuild the shown digits
  task automatic read_display(output logic [15:0] dig, output logic [3:0] dpm,
                              output logic [3:0] seen, output logic bad);
    int idx;
    dig  = 16'hFFFF;
    dpm  = 4'b0000;
    seen = 4'b0000;
    bad  = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      idx = -1;
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: bad = 1'b1;
      endcase
      if (idx >= 0) begin
        dig[idx*4 +: 4] = seg2dig(seg);
        dpm[idx]        = ~dp;
        seen[idx]       = 1'b1;
      end
    end
    step(1);
  endtask

  logic [15:0] dig;
  logic [3:0]  dpm;
  logic [3:0]  seen;
  logic        bad;
  int          wcnt;

  initial begin
    reset = 1'b1;
    slow  = 1'b0;
    bs    = 1'b0;
    bl    = 1'b0;
    step(3);

    // Reset state
    check("rst_bcd", {16'h0, bcd}, 32'h0000);
    check("rst_running", {31'h0, running}, 32'd0);
    check("rst_wrap", {31'h0, wrap}, 32'd0);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'd1);
    reset = 1'b0;
    step(2);

    // Table-driven FSM / counting vectors
    vecs.push_back('{OP_TICK,  5,   16'h0000, 1'b0});
    vecs.push_back('{OP_LAP,   0,   16'h0000, 1'b0});
    vecs.push_back('{OP_START, 0,   16'h0000, 1'b1});
    vecs.push_back('{OP_TICK,  250, 16'h0250, 1'b1});
    vecs.push_back('{OP_START, 0,   16'h0250, 1'b0});
    vecs.push_back('{OP_TICK,  10,  16'h0250, 1'b0});
    vecs.push_back('{OP_LAP,   0,   16'h0000, 1'b0});
    vecs.push_back('{OP_START, 0,   16'h0000, 1'b1});
    vecs.push_back('{OP_TICK,  77,  16'h0077, 1'b1});
    vecs.push_back('{OP_START, 0,   16'h0077, 1'b0});
    vecs.push_back('{OP_LAP,   0,   16'h0000, 1'b0});
    vecs.push_back('{OP_BOTH,  0,   16'h0000, 1'b1});
    vecs.push_back('{OP_TICK,  3,   16'h0003, 1'b1});
    vecs.push_back('{OP_START, 0,   16'h0003, 1'b0});
    vecs.push_back('{OP_LAP,   0,   16'h0000, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_TICK:  ticks(vecs[i].n, 10);
        OP_START: press(1'b1, 1'b0);
        OP_LAP:   press(1'b0, 1'b1);
        default:  press(1'b1, 1'b1);
      endcase
      check($sformatf("vec%0d_bcd", i), {16'h0, bcd}, {16'h0, vecs[i].exp_bcd});
      check($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, vecs[i].exp_run});
      if (i == 12) begin
        // After start+lap together from IDLE the display must be live, not a lap latch
        read_display(dig, dpm, seen, bad);
        check("both_disp_live", {16'h0, dig}, 32'h0003);
      end
    end

    // Lap freeze: display holds 0123 while the count moves on
    press(1'b1, 1'b0);
    ticks(123, 10);
    check("lap_pre_bcd", {16'h0, bcd}, 32'h0123);
    press(1'b0, 1'b1);
    read_display(dig, dpm, seen, bad);
    check("lap_disp_0123", {16'h0, dig}, 32'h0123);
    check("lap_running", {31'h0, running}, 32'd1);
    ticks(7, 10);
    check("lap_bcd_0130", {16'h0, bcd}, 32'h0130);
    read_display(dig, dpm, seen, bad);
    check("lap_disp_frozen", {16'h0, dig}, 32'h0123);
    press(1'b0, 1'b1);
    read_display(dig, dpm, seen, bad);
    check("lap_disp_resumed", {16'h0, dig}, 32'h0130);
    check("lap_resumed_running", {31'h0, running}, 32'd1);

    // Scan pattern at 12.05
    ticks(1075, 2);
    check("scan_bcd", {16'h0, bcd}, 32'h1205);
    read_display(dig, dpm, seen, bad);
    check("scan_digits", {16'h0, dig}, 32'h1205);
    check("scan_dp_only_digit2", {28'h0, dpm}, 32'b0100);
    check("scan_all_slots", {28'h0, seen}, 32'hF);
    check("scan_an_legal", {31'h0, bad}, 32'd0);

    // Wrap 99.99 -> 00.00
    ticks(8794, 2);
    check("wrap_pre_bcd", {16'h0, bcd}, 32'h9999);
    check("wrap_pre_flag", {31'h0, wrap}, 32'd0);
    wcnt = 0;
    for (int i = 0; i < 12; i++) begin
      slow = (i < 2);
      @(negedge clk);
      if (wrap === 1'b1) wcnt++;
      @(posedge clk);
      #1;
    end
    check("wrap_pulse_count", wcnt, 32'd1);
    check("wrap_bcd", {16'h0, bcd}, 32'h0000);
    check("wrap_running", {31'h0, running}, 32'd1);

    // Asynchronous reset mid-run at 00.42
    ticks(42, 10);
    check("mid_pre_bcd", {16'h0, bcd}, 32'h0042);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_bcd", {16'h0, bcd}, 32'h0000);
    check("mid_rst_running", {31'h0, running}, 32'd0);
    check("mid_rst_an", {28'h0, an}, 32'hF);
    check("mid_rst_seg", {25'h0, seg}, 32'h7F);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2);
    ticks(5, 10);
    check("post_rst_idle_bcd", {16'h0, bcd}, 32'h0000);
    check("post_rst_idle_running", {31'h0, running}, 32'd0);
    press(1'b1, 1'b0);
    ticks(2, 10);
    check("post_rst_run_bcd", {16'h0, bcd}, 32'h0002);
    check("post_rst_run_running", {31'h0, running}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
